// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze, branch squash
// and interrupt entry (drain the pipe with NOPs, then ack until irq drops).
module hazard_stall_ctrl #(
   parameter int RF_ADDR_W        = 5,
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int DRAIN_CYCLES     = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 dec_valid,
   input  logic                 dec_reads_rs,
   input  logic                 dec_reads_rd,
   input  logic [RF_ADDR_W-1:0] dec_rs_addr,
   input  logic [RF_ADDR_W-1:0] dec_rd_addr,
   input  logic                 ex_is_load,
   input  logic                 ex_writes_rf,
   input  logic [RF_ADDR_W-1:0] ex_wr_addr,
   input  logic                 ex_branch_taken,
   input  logic                 mem_busy,
   input  logic                 irq,
   output logic                 stall_fd,
   output logic                 stall_de,
   output logic                 flush_fd,
   output logic                 flush_de,
   output logic                 itr_de,
   output logic                 irq_ack,
   output logic                 irq_active
);

   typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

   state_t     state;
   logic [2:0] bubble_cnt;
   logic [3:0] drain_cnt;
   logic       pend_flush;
   logic       hazard;
   logic       branch;

   always_comb begin
      hazard = dec_valid & ex_is_load & ex_writes_rf & (ex_wr_addr != '0) &
               ((dec_reads_rs & (dec_rs_addr == ex_wr_addr)) |
                (dec_reads_rd & (dec_rd_addr == ex_wr_addr)));
      branch = ex_branch_taken | pend_flush;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= RUN;
         bubble_cnt <= '0;
         drain_cnt  <= '0;
         pend_flush <= 1'b0;
      end else if (mem_busy) begin
         // Whole pipe frozen; a branch resolved now is replayed once the freeze ends.
         if (ex_branch_taken)
            pend_flush <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (branch) begin
                  pend_flush <= 1'b0;
                  bubble_cnt <= '0;
               end else if (hazard && bubble_cnt == '0) begin
                  bubble_cnt <= 3'(LOAD_USE_BUBBLES - 1);
               end else if (bubble_cnt != '0) begin
                  bubble_cnt <= bubble_cnt - 3'd1;
               end
               if (irq) begin
                  state      <= DRAIN;
                  drain_cnt  <= 4'(DRAIN_CYCLES - 1);
                  bubble_cnt <= '0;
               end
            end
            DRAIN: begin
               pend_flush <= 1'b0;
               if (drain_cnt == '0)
                  state <= ACK;
               else
                  drain_cnt <= drain_cnt - 4'd1;
            end
            ACK: begin
               if (!irq)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_comb begin
      stall_fd   = 1'b0;
      stall_de   = 1'b0;
      flush_fd   = 1'b0;
      flush_de   = 1'b0;
      itr_de     = 1'b0;
      irq_ack    = 1'b0;
      irq_active = 1'b0;
      if (reset_n) begin
         irq_active = (state != RUN);
         if (mem_busy) begin
            stall_fd = 1'b1;
            stall_de = 1'b1;
         end else if (state == DRAIN) begin
            itr_de   = 1'b1;
            flush_fd = 1'b1;
         end else if (state == ACK) begin
            stall_fd = 1'b1;
            itr_de   = 1'b1;
            irq_ack  = 1'b1;
         end else if (branch) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
         end else if (hazard || bubble_cnt != '0) begin
            stall_fd = 1'b1;
            flush_de = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; two instances cover LOAD_USE_BUBBLES of 1 and 2.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       dec_valid, dec_reads_rs, dec_reads_rd;
   logic [4:0] dec_rs_addr, dec_rd_addr, ex_wr_addr;
   logic       ex_is_load, ex_writes_rf, ex_branch_taken, mem_busy, irq;

   logic [6:0] o1, o2;  // {stall_fd, stall_de, flush_fd, flush_de, itr_de, irq_ack, irq_active}

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] BUSY = 7'b1100000;
   localparam logic [6:0] BSYA = 7'b1100001;
   localparam logic [6:0] LU   = 7'b1001000;
   localparam logic [6:0] BR   = 7'b0011000;
   localparam logic [6:0] DR   = 7'b0010101;
   localparam logic [6:0] AK   = 7'b1000111;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.RF_ADDR_W(5), .LOAD_USE_BUBBLES(1), .DRAIN_CYCLES(3)) dut1 (
      .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_reads_rs(dec_reads_rs),
      .dec_reads_rd(dec_reads_rd), .dec_rs_addr(dec_rs_addr), .dec_rd_addr(dec_rd_addr),
      .ex_is_load(ex_is_load), .ex_writes_rf(ex_writes_rf), .ex_wr_addr(ex_wr_addr),
      .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .irq(irq),
      .stall_fd(o1[6]), .stall_de(o1[5]), .flush_fd(o1[4]), .flush_de(o1[3]),
      .itr_de(o1[2]), .irq_ack(o1[1]), .irq_active(o1[0]));

   hazard_stall_ctrl #(.RF_ADDR_W(5), .LOAD_USE_BUBBLES(2), .DRAIN_CYCLES(3)) dut2 (
      .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_reads_rs(dec_reads_rs),
      .dec_reads_rd(dec_reads_rd), .dec_rs_addr(dec_rs_addr), .dec_rd_addr(dec_rd_addr),
      .ex_is_load(ex_is_load), .ex_writes_rf(ex_writes_rf), .ex_wr_addr(ex_wr_addr),
      .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .irq(irq),
      .stall_fd(o2[6]), .stall_de(o2[5]), .flush_fd(o2[4]), .flush_de(o2[3]),
      .itr_de(o2[2]), .irq_ack(o2[1]), .irq_active(o2[0]));

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
   task automatic cyc(input string tag, input logic [6:0] e1, input logic [6:0] e2);
      @(negedge clk);
      check({tag, "/b1"}, o1, e1);
      check({tag, "/b2"}, o2, e2);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dec_valid = 0; dec_reads_rs = 0; dec_reads_rd = 0;
      dec_rs_addr = '0; dec_rd_addr = '0; ex_wr_addr = '0;
      ex_is_load = 0; ex_writes_rf = 0; ex_branch_taken = 0; mem_busy = 0; irq = 0;
   endtask

   initial begin
      idle();
      reset_n = 0;
      mem_busy = 1; irq = 1; ex_branch_taken = 1;
      @(posedge clk); #1;
      cyc("reset_forced", NONE, NONE);
      idle();
      cyc("reset_idle", NONE, NONE);
      reset_n = 1;
      cyc("run_idle", NONE, NONE);

      // load-use on rs
      dec_valid = 1; dec_reads_rs = 1; dec_rs_addr = 5'd3;
      ex_is_load = 1; ex_writes_rf = 1; ex_wr_addr = 5'd3;
      cyc("lu_rs_c0", LU, LU);
      ex_is_load = 0;
      cyc("lu_rs_c1", NONE, LU);
      cyc("lu_rs_c2", NONE, NONE);

      // load-use on rd
      dec_reads_rs = 0; dec_reads_rd = 1; dec_rd_addr = 5'd7;
      ex_is_load = 1; ex_wr_addr = 5'd7;
      cyc("lu_rd_c0", LU, LU);
      idle();
      cyc("lu_rd_c1", NONE, LU);
      cyc("lu_rd_c2", NONE, NONE);

      // r0 never hazards; invalid decode never hazards; non-writing load never hazards
      dec_valid = 1; dec_reads_rs = 1; dec_rs_addr = '0;
      ex_is_load = 1; ex_writes_rf = 1; ex_wr_addr = '0;
      cyc("lu_r0", NONE, NONE);
      dec_rs_addr = 5'd9; ex_wr_addr = 5'd9; dec_valid = 0;
      cyc("lu_nodec", NONE, NONE);
      dec_valid = 1; ex_writes_rf = 0;
      cyc("lu_nowrite", NONE, NONE);
      idle();

      // branch held through 3 busy cycles, flushed once afterwards
      mem_busy = 1; ex_branch_taken = 1;
      cyc("br_busy0", BUSY, BUSY);
      cyc("br_busy1", BUSY, BUSY);
      cyc("br_busy2", BUSY, BUSY);
      idle();
      cyc("br_pend", BR, BR);
      cyc("br_done", NONE, NONE);

      // branch beats load-use and cancels remaining bubbles
      dec_valid = 1; dec_reads_rs = 1; dec_rs_addr = 5'd4;
      ex_is_load = 1; ex_writes_rf = 1; ex_wr_addr = 5'd4; ex_branch_taken = 1;
      cyc("br_vs_lu", BR, BR);
      idle();
      cyc("br_cancel", NONE, NONE);

      // interrupt entry, 3 drain cycles
      irq = 1;
      cyc("irq_run", NONE, NONE);
      cyc("irq_dr0", DR, DR);
      cyc("irq_dr1", DR, DR);
      cyc("irq_dr2", DR, DR);
      cyc("irq_ak0", AK, AK);
      cyc("irq_ak1", AK, AK);
      irq = 0;
      cyc("irq_ak_drop", AK, AK);
      cyc("irq_ret", NONE, NONE);

      // busy for 2 cycles mid-drain stretches it to 5
      irq = 1;
      cyc("bd_run", NONE, NONE);
      cyc("bd_dr0", DR, DR);
      mem_busy = 1;
      cyc("bd_busy0", BSYA, BSYA);
      cyc("bd_busy1", BSYA, BSYA);
      mem_busy = 0;
      cyc("bd_dr1", DR, DR);
      cyc("bd_dr2", DR, DR);
      cyc("bd_ak", AK, AK);
      irq = 0;
      cyc("bd_ak_drop", AK, AK);
      cyc("bd_ret", NONE, NONE);

      // reset during ACK abandons the sequence; a held irq restarts a full drain
      irq = 1;
      cyc("ra_run", NONE, NONE);
      cyc("ra_dr0", DR, DR);
      cyc("ra_dr1", DR, DR);
      cyc("ra_dr2", DR, DR);
      cyc("ra_ak", AK, AK);
      reset_n = 0;
      cyc("ra_reset", NONE, NONE);
      reset_n = 1;
      cyc("ra_restart", NONE, NONE);
      cyc("ra_dr0b", DR, DR);
      cyc("ra_dr1b", DR, DR);
      cyc("ra_dr2b", DR, DR);
      cyc("ra_akb", AK, AK);
      irq = 0;
      cyc("ra_ak_drop", AK, AK);
      cyc("ra_ret", NONE, NONE);

      // irq together with a branch: flush now, drain next
      irq = 1; ex_branch_taken = 1;
      cyc("ib_br", BR, BR);
      ex_branch_taken = 0;
      cyc("ib_dr0", DR, DR);
      cyc("ib_dr1", DR, DR);
      cyc("ib_dr2", DR, DR);
      irq = 0;
      cyc("ib_ak", AK, AK);
      cyc("ib_ret", NONE, NONE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Control-side counterpart of the decode/execute pipeline register.
- Generates the stall, flush and itr signals that the fetch/decode and decode/execute registers consume.
- Detects load-use hazards, memory-wait freezes and taken-branch squashes.
- Sequences interrupt entry: drain the pipe with injected NOPs, then handshake with the interrupt source.

Parameters:
- RF_ADDR_W, 5, register-file address width.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- DRAIN_CYCLES, 3, cycles of NOP injection before irq_ack (1..15).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- dec_valid  in  1  decode stage holds a real instruction.
- dec_reads_rs  in  1  decode instruction reads rs.
- dec_reads_rd  in  1  decode instruction reads rd.
- dec_rs_addr  in  RF_ADDR_W  decode rs index.
- dec_rd_addr  in  RF_ADDR_W  decode rd index.
- ex_is_load  in  1  execute stage holds a load.
- ex_writes_rf  in  1  execute instruction writes the register file.
- ex_wr_addr  in  RF_ADDR_W  execute destination index.
- ex_branch_taken  in  1  execute resolved a taken branch/jump.
- mem_busy  in  1  data memory not ready; whole pipe must freeze.
- irq  in  1  level interrupt request.
- stall_fd  out  1  hold fetch/decode register.
- stall_de  out  1  hold decode/execute register.
- flush_fd  out  1  squash fetch/decode register.
- flush_de  out  1  load NOP into decode/execute register.
- itr_de  out  1  interrupt NOP injection into decode/execute register.
- irq_ack  out  1  interrupt accepted; held until irq drops.
- irq_active  out  1  high in DRAIN and ACK states.

Behaviour:
- Reset: while reset_n=0 at a rising edge:
  - state=RUN, bubble_cnt=0, drain_cnt=0, pend_flush=0.
  - All outputs are combinationally forced to 0 while reset_n=0.
  - Reset mid-drain or mid-ack abandons the sequence with no ack.
- FSM states:
  - RUN -> DRAIN when irq=1 and mem_busy=0; drain_cnt loads DRAIN_CYCLES-1.
  - DRAIN -> ACK when drain_cnt=0 and mem_busy=0; otherwise drain_cnt decrements each non-busy cycle.
  - ACK -> RUN when irq=0.
- Outputs are combinational from state, counters and inputs, applied in the same cycle. Priority, highest first:
  1. mem_busy=1:
     - stall_fd=stall_de=1, all flush/itr=0.
     - FSM and counters frozen.
     - If ex_branch_taken=1, set pend_flush.
  2. DRAIN:
     - itr_de=1, flush_fd=1, irq_active=1.
     - A pending or new branch flush is absorbed: pend_flush cleared, since the drain already squashes.
  3. ACK:
     - stall_fd=1, itr_de=1, irq_ack=1, irq_active=1.
     - Fetch stays frozen until return to RUN.
  4. Branch (ex_branch_taken=1 or pend_flush=1 in RUN):
     - flush_fd=flush_de=1 for exactly one cycle.
     - pend_flush cleared.
     - Any load-use stall or remaining bubble_cnt is cancelled to 0.
  5. Load-use:
     - Hazard condition: dec_valid & ex_is_load & ex_writes_rf & ex_wr_addr!=0 & ((dec_reads_rs & dec_rs_addr==ex_wr_addr) | (dec_reads_rd & dec_rd_addr==ex_wr_addr)).
     - Hazard, or bubble_cnt>0, gives stall_fd=1, flush_de=1, stall_de=0.
     - On a new hazard with bubble_cnt=0, bubble_cnt loads LOAD_USE_BUBBLES-1; otherwise it decrements toward 0.
- Simultaneous events:
  - irq in the same cycle as a branch in RUN: the branch flush is issued that cycle and the FSM still enters DRAIN.
  - irq while bubble_cnt>0: bubble_cnt is cleared on entering DRAIN.
- Stall and flush are never both asserted on the same register in one cycle.
- Register index 0 never causes a hazard.

Test Plan:
- Load-use: ex load writing r3, decode reads rs=r3, LOAD_USE_BUBBLES=1 -> one cycle stall_fd=1, flush_de=1; next cycle (ex no longer load) all 0.
- LOAD_USE_BUBBLES=2, same hazard -> stall_fd/flush_de high exactly 2 cycles; with ex_wr_addr=0 -> no stall.
- Branch during mem_busy: ex_branch_taken=1 while mem_busy=1 for 3 cycles -> stall_fd/stall_de=1 for 3 cycles, then flush_fd=flush_de=1 for exactly 1 cycle.
- irq=1 in RUN, DRAIN_CYCLES=3 -> itr_de/flush_fd high 3 cycles, then irq_ack=1 until irq=0, then RUN with all outputs 0 the following cycle.
- irq with mem_busy pulsed 2 cycles mid-drain -> drain lasts 5 cycles total; counter does not advance while busy.
- reset_n=0 during ACK -> next cycle all outputs 0 and irq_ack=0; new irq restarts a full DRAIN.
